// File: rtl/onehot_encoder.sv
// onehot_encoder: registered one-hot to binary encoder with valid/ready on both sides.
// Optional saturating illegal-word counter (err_cnt_o) compiled in with ONEHOT_ENC_ERR_CNT_EN.
module onehot_encoder #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [N-1:0]         in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [$clog2(N)-1:0] out_code_o,
`ifdef ONEHOT_ENC_ERR_CNT_EN
    output logic [CNT_W-1:0]     err_cnt_o,
`endif
    output logic                 out_err_o
);
    localparam int W = $clog2(N);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   code_q, code_d, enc;
    logic           err_q, err_d, illegal, accept;

    assign out_valid_o = (state_q == FULL);
    assign in_ready_o  = !out_valid_o || out_ready_i;
    assign accept      = in_valid_i && in_ready_o;
    assign out_code_o  = code_q;
    assign out_err_o   = err_q;

    // Highest set bit wins; zero input encodes to 0. Legal means exactly one bit set.
    always_comb begin
        enc = '0;
        for (int i = 0; i < N; i++)
            if (in_data_i[i]) enc = W'(i);
        illegal = (in_data_i == '0) || ((in_data_i & (in_data_i - N'(1))) != '0);
    end

    // Next state: accept fills (or refills on simultaneous drain), drain alone empties.
    always_comb begin
        state_d = accept ? FULL : (out_ready_i ? EMPTY : state_q);
        code_d  = accept ? enc : code_q;
        err_d   = accept ? illegal : err_q;
    end

    // Output register; reset drops any pending word immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

`ifdef ONEHOT_ENC_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign err_cnt_o = cnt_q;

    // Count accepted illegal words, sticking at all-ones.
    always_comb cnt_d = (accept && illegal && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_onehot_encoder.sv
// tb_onehot_encoder: scoreboard bench for onehot_encoder (N=4, CNT_W=2); err_cnt checks with ONEHOT_ENC_ERR_CNT_EN.
module tb_onehot_encoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_code;
    logic       out_err;
    logic [1:0] err_cnt;
    logic [2:0] exp_q[$];
    logic [2:0] mon_e;
    int         n_cmp = 0;
    int         n_err = 0;

    onehot_encoder #(.N(4), .CNT_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_code_o  (out_code),
`ifdef ONEHOT_ENC_ERR_CNT_EN
        .err_cnt_o   (err_cnt),
`endif
        .out_err_o   (out_err)
    );

`ifndef ONEHOT_ENC_ERR_CNT_EN
    assign err_cnt = '0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cnt(input string name, input int exp);
`ifdef ONEHOT_ENC_ERR_CNT_EN
        check(name, int'(err_cnt), exp);
`endif
    endtask

    // Issue a word with its hand-computed result; returns just after the accepting edge.
    task automatic send(input logic [3:0] d, input logic [1:0] c, input logic e);
        bit done = 0;
        exp_q.push_back({c, e});
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) check("send timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    // Monitor: every transfer on the output side must match the next expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected output", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("out_code", int'(out_code), int'(mon_e[2:1]));
                check("out_err", int'(out_err), int'(mon_e[0]));
            end
        end
    end

    initial begin
        #1;
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_code", int'(out_code), 0);
        check("reset out_err", int'(out_err), 0);
        check("reset in_ready", int'(in_ready), 1);
        check_cnt("reset err_cnt", 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // legal stream back to back
        send(4'b0001, 2'd0, 1'b0);
        send(4'b0010, 2'd1, 1'b0);
        send(4'b0100, 2'd2, 1'b0);
        send(4'b1000, 2'd3, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("stream drained", exp_q.size(), 0);
        check("stream out_valid low", int'(out_valid), 0);
        check_cnt("stream err_cnt", 0);
        // illegal words
        send(4'b0000, 2'd0, 1'b1);
        send(4'b1010, 2'd3, 1'b1);
        send(4'b0110, 2'd2, 1'b1);
        idle(2);
        check("illegal drained", exp_q.size(), 0);
        check_cnt("illegal err_cnt", 3);
        // backpressure
        send(4'b0100, 2'd2, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'b1000;
        exp_q.push_back({2'd3, 1'b0});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall in_ready", int'(in_ready), 0);
            check("stall out_code", int'(out_code), 2);
            check("stall out_valid", int'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("refill out_valid", int'(out_valid), 1);
        check("refill out_code", int'(out_code), 3);
        idle(2);
        check("bp drained", exp_q.size(), 0);
        // reset mid-operation
        out_ready = 1'b0;
        send(4'b0010, 2'd1, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("async out_valid", int'(out_valid), 0);
        check("async out_code", int'(out_code), 0);
        check("async in_ready", int'(in_ready), 1);
        check_cnt("async err_cnt", 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no ghost", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        // saturation with CNT_W = 2
        send(4'b0000, 2'd0, 1'b1);
        check_cnt("sat 1", 1);
        send(4'b0000, 2'd0, 1'b1);
        check_cnt("sat 2", 2);
        send(4'b0000, 2'd0, 1'b1);
        check_cnt("sat 3", 3);
        send(4'b0000, 2'd0, 1'b1);
        check_cnt("sat 4", 3);
        send(4'b0000, 2'd0, 1'b1);
        check_cnt("sat 5", 3);
        idle(3);
        check("final drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/onehot_encoder.md
# onehot_encoder

Registered one-hot to binary encoder with valid/ready handshake on both sides; the inverse of the team's 2-to-4 decoder. Accepts an N-bit one-hot word and returns its binary index one cycle later. Flags and optionally counts illegal inputs (zero or multiple bits set). Sits between one-hot request/grant logic and binary-indexed consumers.

## Interface
- N, default 4: input vector width; must be a power of two and ≥ 2. Output width W = $clog2(N), a derived localparam.
- CNT_W, default 8: width of the error counter.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  N  one-hot input word.
- out_valid  output  1  out_code and out_err are valid.
- out_ready  input  1  consumer takes the output this cycle.
- out_code  output  W  binary index of the input bit.
- out_err  output  1  the accepted word was not exactly one-hot.
- err_cnt  output  CNT_W  saturating count of illegal words. Present only with ONEHOT_ENC_ERR_CNT_EN.

## Operation
- Single-entry output register (pipeline stage).
- in_ready = !out_valid || out_ready. This is combinational and depends on no input other than out_ready.
- Accept: in_valid && in_ready. On accept:
  - out_valid <= 1.
  - out_code <= index of the highest set bit of in_data, or 0 when in_data == 0.
  - out_err <= 1 when popcount(in_data) != 1, else 0.
- Drain: out_valid && out_ready with no accept in the same cycle -> out_valid <= 0. out_code and out_err hold their last values.
- Simultaneous drain and accept: the new word replaces the old one. out_valid stays 1, giving a throughput of one word per cycle.
- Stall: while out_valid && !out_ready, out_code and out_err hold stable and in_ready = 0.
- in_data is ignored when in_valid = 0. No state changes.
- Error counter (when compiled in): increments by 1 on each accepted word with an illegal pattern. It saturates at 2^CNT_W − 1 and never wraps. It is cleared only by reset.
- States: EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on stall, or on drain with accept.

## Timing
- Latency: 1 cycle from the accept edge to out_valid = 1 with the corresponding code.
- Reset values: out_valid = 0, out_code = 0, out_err = 0, err_cnt = 0. in_ready = 1 during and after reset.
- Reset asserted mid-operation: any pending output is dropped immediately (asynchronous). No ghost word appears after release.
- First accept is possible on the first rising edge after rst_n deasserts.
- No combinational path from in_valid or in_data to any output.

## Configuration
- ONEHOT_ENC_ERR_CNT_EN defined: the err_cnt port and the saturating counter exist as described above.
- ONEHOT_ENC_ERR_CNT_EN undefined: the err_cnt port and counter logic are absent. out_err behaviour is unchanged.

## Test plan
- N = 4, out_ready = 1, legal stream: feed 0001, 0010, 0100, 1000 on consecutive cycles.
  - Required: out_code = 0, 1, 2, 3 on consecutive cycles, each one cycle after its accept.
  - Required: out_err = 0 throughout, out_valid high for 4 cycles, err_cnt = 0.
- Illegal inputs:
  - 0000 -> out_code = 0, out_err = 1.
  - 1010 -> out_code = 3, out_err = 1.
  - 0110 -> out_code = 2, out_err = 1.
  - Required: err_cnt = 3 afterwards.
- Backpressure:
  - Accept 0100, then hold out_ready = 0 for 3 cycles while in_valid = 1 with 1000. Required: out_code stays 2 and in_ready = 0 for those cycles.
  - Then raise out_ready. Required: 2 is consumed, 1000 is accepted the same cycle, and out_code = 3 on the next cycle.
- Saturation: CNT_W = 2, feed 5 consecutive 0000 words. Required: err_cnt reads 1, 2, 3, 3, 3.
- Reset mid-operation:
  - Accept 0010 with out_ready = 0, then pulse rst_n low between clock edges. Required: out_valid = 0, out_code = 0 and err_cnt = 0 immediately; in_ready = 1.
  - After release, no output appears until a new accept.
- Macro off: build without ONEHOT_ENC_ERR_CNT_EN and rerun the illegal-input test. Required: out_err results identical, and the design compiles without the err_cnt port.
